msk_rx_acq_ctrl: RTL and testbench
==================================

// Module: msk_rx_acq_ctrl
// PURPOSE
//  Acquisition sequencer for the MSK RX chain (gardner_ted/pi_loop_filter timing loop,
//  coarse_cfo, derotator/phase_detector/loop_filter_cfo carrier loop).
//  Replaces fixed-delay enables with a lock-driven FSM: timing acq -> coarse CFO -> fine carrier
//  -> track. Monitors windowed mean |error| for lock/unlock; reports status and relock count.
// PARAMETERS
//  WERR        18    timing error width (signed, gardner e_out_o)
//  EW          24    phase error width (signed, phase_detector phase_err)
//  LOCK_WIN    128   err samples per lock window; power of 2
//  SETTLE_SYMS 64    symbols ignored after entering TIM_ACQ / FINE_ACQ
//  TIMEOUT     4096  symbols allowed per acquisition state
//  MAX_TRY     3     coarse+fine attempts before FAIL
//  TED_THR     2048  timing lock: window mean |ted_err| < TED_THR
//  PD_THR      4096  carrier lock: window mean |pd_err| < PD_THR
//  PD_UNLK     16384 carrier unlock in TRACK: mean |pd_err| > PD_UNLK
//  TED_UNLK    8192  timing unlock in TRACK: mean |ted_err| > TED_UNLK
// PORTS
//  clk          in   1     system clock
//  reset_n      in   1     asynchronous reset, active low
//  start_i      in   1     1-clk pulse: (re)start acquisition
//  sym_val_i    in   1     interpolator symbol strobe
//  ted_err_i    in   WERR  timing error, signed
//  ted_err_val_i in  1     timing error valid
//  pd_err_i     in   EW    phase error, signed
//  pd_err_val_i in   1     phase error valid
//  cfo_done_i   in   1     coarse CFO estimate-valid pulse
//  ted_en_o     out  1     enable timing loop
//  coarse_en_o  out  1     coarse_cfo enable
//  cfo_en_o     out  1     derotator / phase detector enable
//  lock_o       out  1     full lock (TRACK)
//  fail_o       out  1     acquisition failed, level until start_i
//  state_o      out  3     current FSM state encoding
//  relock_cnt_o out  8     unlock events from TRACK, saturating at 255
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, tries, accumulators 0.
//  Clocking: single clk domain; all outputs registered, Moore on state.
//  Output change lags the decision cycle by 1 clk.
//  States:
//   IDLE=0: all enables 0. start_i -> TIM_ACQ.
//   TIM_ACQ=1: ted_en. After SETTLE_SYMS sym_val_i, TED window runs.
//    Window mean < TED_THR -> COARSE (tries=0).
//    Sym count reaches TIMEOUT -> FAIL.
//   COARSE=2: ted_en, coarse_en. cfo_done_i -> FINE_ACQ. TIMEOUT -> FAIL.
//   FINE_ACQ=3: ted_en, cfo_en. After SETTLE_SYMS, PD window runs.
//    Mean < PD_THR -> TRACK.
//    TIMEOUT: tries+1; if tries+1 < MAX_TRY -> COARSE, else -> FAIL.
//   TRACK=4: ted_en, cfo_en, lock.
//    PD mean > PD_UNLK -> FINE_ACQ, relock+1.
//    TED mean > TED_UNLK -> TIM_ACQ, relock+1; takes priority over PD unlock.
//   FAIL=5: fail_o=1, enables 0. Only start_i leaves -> TIM_ACQ.
//  Priorities:
//   start_i in any state wins over every other transition.
//   start_i clears tries and the state symbol counter; it does not clear relock_cnt_o.
//   Lock decision in the same cycle as timeout: lock wins.
//  Window (per detector):
//   Counts err_val pulses, not clocks.
//   acc += |err|; |most-negative| saturates to max positive.
//   acc width = W+log2(LOCK_WIN).
//   At the LOCK_WIN-th sample: mean = acc>>log2(LOCK_WIN), registered with a 1-clk done flag;
//   acc restarts.
//   Decision cycle = done cycle.
//   Detectors clear on every state entry and run only in states that use them.
//  Symbol counter: counts sym_val_i, clears on state entry, saturates at TIMEOUT.
//  Reset mid-operation: immediate return to IDLE, outputs 0 asynchronously.
// STRUCTURE
//  Shared pkg msk_rx_ctrl_pkg:
//   typedef enum logic [2:0] acq_state_t {IDLE,TIM_ACQ,COARSE,FINE_ACQ,TRACK,FAIL}.
//  Sub-module msk_lock_det #(W, LOCK_WIN): clr, err, err_val -> mean, mean_val.
//   Instantiated for TED and PD.
//  Top: FSM, symbol counter, try counter, relock counter.
// TESTING
//  1 Reset, idle:
//    no start -> all outputs 0, state_o=0 for 1000 clks.
//  2 Nominal:
//    start; ted_err=±100 after 64 syms -> COARSE at clk after 192nd sym window;
//    cfo_done -> FINE_ACQ; pd_err=±200 -> lock_o=1, state_o=4.
//  3 Timing timeout:
//    ted_err=±10000 forever -> fail_o=1 exactly at 4096th sym; start_i -> state_o=1, fail_o=0.
//  4 Retry:
//    pd_err=±30000 in FINE_ACQ -> COARSE twice, FAIL after 3rd timeout;
//    pd_err=-2^23 checks abs saturation.
//  5 Unlock:
//    in TRACK pd_err=±20000 one window -> FINE_ACQ, relock_cnt_o=1;
//    ted_err=±9000 with same -> TIM_ACQ (TED priority).
//  6 Async reset mid-COARSE:
//    reset_n low off-edge -> outputs 0 same instant;
//    start_i coincident with a lock decision -> TIM_ACQ.

Source files
------------

// File: rtl/msk_rx_ctrl_pkg.sv
// Shared types for the MSK RX acquisition control path.
// State encoding is visible on state_o, so the values are fixed.
package msk_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TIM_ACQ  = 3'd1,
    COARSE   = 3'd2,
    FINE_ACQ = 3'd3,
    TRACK    = 3'd4,
    FAIL     = 3'd5
  } acq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/msk_lock_det.sv
// Windowed mean |err| over LOCK_WIN valid samples; mean_val pulses 1 clk after the last sample.
// No backpressure: every err_val is consumed; clr drops the partial window and any pending result.
module msk_lock_det #(
  parameter int W        = 18,
  parameter int LOCK_WIN = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] err,
  input  logic         err_val,
  output logic [W-1:0] mean,
  output logic         mean_val
);

  localparam int LW = $clog2(LOCK_WIN);
  localparam int AW = W + LW;

  logic [AW-1:0] r_acc;
  logic [LW-1:0] r_cnt;
  logic [W-1:0]  r_mean;
  logic          r_mean_val;
  logic [W-1:0]  w_abs;
  logic [AW-1:0] w_sum;
  logic          w_last;

  // The most negative code has no positive twin, so clamp it to the max positive value.
  always_comb begin
    w_abs = err;
    if (err[W-1]) begin
      if (err == {1'b1, {(W-1){1'b0}}}) begin
        w_abs = {1'b0, {(W-1){1'b1}}};
      end else begin
        w_abs = -err;
      end
    end
  end

  assign w_sum  = r_acc + AW'(w_abs);
  assign w_last = (r_cnt == LW'(LOCK_WIN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mean     <= '0;
      r_mean_val <= 1'b0;
    end else if (clr) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mean_val <= 1'b0;
    end else begin
      r_mean_val <= 1'b0;
      if (err_val) begin
        if (w_last) begin
          r_mean     <= w_sum[AW-1:LW];
          r_mean_val <= 1'b1;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + LW'(1);
        end
      end
    end
  end

  assign mean     = r_mean;
  assign mean_val = r_mean_val;

endmodule

// File: rtl/msk_rx_acq_ctrl.sv
// Lock-driven acquisition sequencer: timing acq -> coarse CFO -> fine carrier -> track.
// Outputs are registered Moore decodes of the state, one clk after the decision; no backpressure.
module msk_rx_acq_ctrl
  import msk_rx_ctrl_pkg::*;
#(
  parameter int WERR        = 18,
  parameter int EW          = 24,
  parameter int LOCK_WIN    = 128,
  parameter int SETTLE_SYMS = 64,
  parameter int TIMEOUT     = 4096,
  parameter int MAX_TRY     = 3,
  parameter int TED_THR     = 2048,
  parameter int PD_THR      = 4096,
  parameter int PD_UNLK     = 16384,
  parameter int TED_UNLK    = 8192
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            sym_val_i,
  input  logic [WERR-1:0] ted_err_i,
  input  logic            ted_err_val_i,
  input  logic [EW-1:0]   pd_err_i,
  input  logic            pd_err_val_i,
  input  logic            cfo_done_i,
  output logic            ted_en_o,
  output logic            coarse_en_o,
  output logic            cfo_en_o,
  output logic            lock_o,
  output logic            fail_o,
  output logic [2:0]      state_o,
  output logic [7:0]      relock_cnt_o
);

  localparam int SCW = $clog2(TIMEOUT + 1);
  localparam int TW  = $clog2(MAX_TRY + 1);

  localparam logic [SCW-1:0]  LP_TMO      = SCW'(TIMEOUT);
  localparam logic [SCW-1:0]  LP_TMO_M1   = SCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0]  LP_SETTLE   = SCW'(SETTLE_SYMS);
  localparam logic [TW-1:0]   LP_MAX_TRY  = TW'(MAX_TRY);
  localparam logic [WERR-1:0] LP_TED_THR  = WERR'(TED_THR);
  localparam logic [WERR-1:0] LP_TED_UNLK = WERR'(TED_UNLK);
  localparam logic [EW-1:0]   LP_PD_THR   = EW'(PD_THR);
  localparam logic [EW-1:0]   LP_PD_UNLK  = EW'(PD_UNLK);

  acq_state_t      r_state;
  acq_state_t      w_nxt;
  logic [SCW-1:0]  r_sym_cnt;
  logic [TW-1:0]   r_tries;
  logic [TW-1:0]   w_tries_inc;
  logic [7:0]      r_relock;
  logic            r_ted_en;
  logic            r_coarse_en;
  logic            r_cfo_en;
  logic            r_lock;
  logic            r_fail;

  logic            w_ted_run;
  logic            w_pd_run;
  logic            w_clr;
  logic            w_tmo;
  logic [WERR-1:0] w_ted_mean;
  logic            w_ted_mean_val;
  logic [EW-1:0]   w_pd_mean;
  logic            w_pd_mean_val;
  logic            w_ted_lock;
  logic            w_ted_unlk;
  logic            w_pd_lock;
  logic            w_pd_unlk;

  assign w_ted_run = ((r_state == TIM_ACQ) && (r_sym_cnt >= LP_SETTLE)) || (r_state == TRACK);
  assign w_pd_run  = ((r_state == FINE_ACQ) && (r_sym_cnt >= LP_SETTLE)) || (r_state == TRACK);

  msk_lock_det #(.W(WERR), .LOCK_WIN(LOCK_WIN)) u_ted_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (w_clr),
    .err      (ted_err_i),
    .err_val  (ted_err_val_i & w_ted_run),
    .mean     (w_ted_mean),
    .mean_val (w_ted_mean_val)
  );

  msk_lock_det #(.W(EW), .LOCK_WIN(LOCK_WIN)) u_pd_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (w_clr),
    .err      (pd_err_i),
    .err_val  (pd_err_val_i & w_pd_run),
    .mean     (w_pd_mean),
    .mean_val (w_pd_mean_val)
  );

  assign w_ted_lock  = w_ted_mean_val && (w_ted_mean < LP_TED_THR);
  assign w_ted_unlk  = w_ted_mean_val && (w_ted_mean > LP_TED_UNLK);
  assign w_pd_lock   = w_pd_mean_val && (w_pd_mean < LP_PD_THR);
  assign w_pd_unlk   = w_pd_mean_val && (w_pd_mean > LP_PD_UNLK);
  assign w_tmo       = sym_val_i && (r_sym_cnt == LP_TMO_M1);
  assign w_tries_inc = r_tries + TW'(1);

  // Lock checks come before timeout in every branch so a coincident lock wins.
  always_comb begin
    w_nxt = r_state;
    if (start_i) begin
      w_nxt = TIM_ACQ;
    end else begin
      case (r_state)
        TIM_ACQ: begin
          if (w_ted_lock)  w_nxt = COARSE;
          else if (w_tmo) w_nxt = FAIL;
        end
        COARSE: begin
          if (cfo_done_i) w_nxt = FINE_ACQ;
          else if (w_tmo) w_nxt = FAIL;
        end
        FINE_ACQ: begin
          if (w_pd_lock)  w_nxt = TRACK;
          else if (w_tmo) w_nxt = (w_tries_inc < LP_MAX_TRY) ? COARSE : FAIL;
        end
        TRACK: begin
          if (w_ted_unlk)     w_nxt = TIM_ACQ;
          else if (w_pd_unlk) w_nxt = FINE_ACQ;
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  // Any state entry, including a start re-entering TIM_ACQ, restarts counting and both windows.
  assign w_clr = start_i || (w_nxt != r_state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sym_cnt   <= '0;
      r_tries     <= '0;
      r_relock    <= '0;
      r_ted_en    <= 1'b0;
      r_coarse_en <= 1'b0;
      r_cfo_en    <= 1'b0;
      r_lock      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_ted_en    <= (w_nxt != IDLE) && (w_nxt != FAIL);
      r_coarse_en <= (w_nxt == COARSE);
      r_cfo_en    <= (w_nxt == FINE_ACQ) || (w_nxt == TRACK);
      r_lock      <= (w_nxt == TRACK);
      r_fail      <= (w_nxt == FAIL);

      if (w_clr) begin
        r_sym_cnt <= '0;
      end else if (sym_val_i && (r_sym_cnt != LP_TMO)) begin
        r_sym_cnt <= r_sym_cnt + SCW'(1);
      end

      if (start_i || ((r_state == TIM_ACQ) && (w_nxt == COARSE))) begin
        r_tries <= '0;
      end else if ((r_state == FINE_ACQ) && (w_nxt == COARSE)) begin
        r_tries <= w_tries_inc;
      end

      if (!start_i && (r_state == TRACK) && (w_nxt != TRACK)) begin
        r_relock <= sat_inc8(r_relock);
      end
    end
  end

  assign ted_en_o     = r_ted_en;
  assign coarse_en_o  = r_coarse_en;
  assign cfo_en_o     = r_cfo_en;
  assign lock_o       = r_lock;
  assign fail_o       = r_fail;
  assign state_o      = r_state;
  assign relock_cnt_o = r_relock;

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Scoreboarded bench: a queue/arithmetic reference predicts each state change and window mean.
module tb_msk_rx_acq_ctrl;

  localparam int WERR = 18, EW = 24, LOCK_WIN = 128, SETTLE = 64, TIMEOUT = 4096;
  localparam int MAX_TRY = 3, TED_THR = 2048, PD_THR = 4096, PD_UNLK = 16384, TED_UNLK = 8192;
  localparam int S_IDLE = 0, S_TIM = 1, S_COARSE = 2, S_FINE = 3, S_TRACK = 4, S_FAIL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, start_i, sym_val_i, ted_err_val_i, pd_err_val_i, cfo_done_i;
  logic [WERR-1:0] ted_err_i;
  logic [EW-1:0]   pd_err_i;
  logic            ted_en_o, coarse_en_o, cfo_en_o, lock_o, fail_o;
  logic [2:0]      state_o;
  logic [7:0]      relock_cnt_o;

  msk_rx_acq_ctrl #(
    .WERR(WERR), .EW(EW), .LOCK_WIN(LOCK_WIN), .SETTLE_SYMS(SETTLE), .TIMEOUT(TIMEOUT),
    .MAX_TRY(MAX_TRY), .TED_THR(TED_THR), .PD_THR(PD_THR), .PD_UNLK(PD_UNLK), .TED_UNLK(TED_UNLK)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .sym_val_i(sym_val_i),
    .ted_err_i(ted_err_i), .ted_err_val_i(ted_err_val_i), .pd_err_i(pd_err_i),
    .pd_err_val_i(pd_err_val_i), .cfo_done_i(cfo_done_i), .ted_en_o(ted_en_o),
    .coarse_en_o(coarse_en_o), .cfo_en_o(cfo_en_o), .lock_o(lock_o), .fail_o(fail_o),
    .state_o(state_o), .relock_cnt_o(relock_cnt_o)
  );

  int checks = 0, failures = 0, cyc = 0;

  typedef struct { int cyc; int st; int relock; } evt_t;
  evt_t q_evt[$];
  int   q_tmean[$];
  int   q_pmean[$];

  // Reference model state
  int m_state = 0, m_sym = 0, m_tries = 0, m_relock = 0;
  int win_ted[$];
  int win_pd[$];
  bit m_ted_due = 0, m_pd_due = 0;
  int m_ted_mean = 0, m_pd_mean = 0;

  int g_ted_mag = 100, g_pd_mag = 200, g_sym_pct = 75;
  bit g_pd_sat = 0, g_same_val = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int abs_sat(input int v, input int w);
    int mn;
    mn = -(1 << (w - 1));
    if (v == mn) return (1 << (w - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rand_err(input int mag);
    int jit, m;
    jit = mag / 50;
    m = mag - jit + int'($urandom_range(0, 2 * jit));
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  function automatic logic [4:0] exp_outs(input int st);
    logic [4:0] o;
    o[4] = (st >= S_TIM) && (st <= S_TRACK);
    o[3] = (st == S_COARSE);
    o[2] = (st == S_FINE) || (st == S_TRACK);
    o[1] = (st == S_TRACK);
    o[0] = (st == S_FAIL);
    return o;
  endfunction

  function automatic int sum_q(input int q[$]);
    longint s;
    s = 0;
    foreach (q[i]) s += q[i];
    return int'(s / LOCK_WIN);
  endfunction

  task automatic model_step(input bit st, input bit sv, input bit tv, input int te,
                            input bit pv, input int pe, input bit cd);
    int nxt;
    bit tmo;
    nxt = m_state;
    tmo = sv && (m_sym == TIMEOUT - 1);
    if (st) begin
      nxt = S_TIM;
      m_tries = 0;
    end else begin
      case (m_state)
        S_TIM: begin
          if (m_ted_due && m_ted_mean < TED_THR) begin nxt = S_COARSE; m_tries = 0; end
          else if (tmo) nxt = S_FAIL;
        end
        S_COARSE: begin
          if (cd) nxt = S_FINE;
          else if (tmo) nxt = S_FAIL;
        end
        S_FINE: begin
          if (m_pd_due && m_pd_mean < PD_THR) nxt = S_TRACK;
          else if (tmo) begin
            if (m_tries + 1 < MAX_TRY) begin m_tries++; nxt = S_COARSE; end
            else nxt = S_FAIL;
          end
        end
        S_TRACK: begin
          if (m_ted_due && m_ted_mean > TED_UNLK) begin
            nxt = S_TIM;
            if (m_relock < 255) m_relock++;
          end else if (m_pd_due && m_pd_mean > PD_UNLK) begin
            nxt = S_FINE;
            if (m_relock < 255) m_relock++;
          end
        end
        default: ;
      endcase
    end
    m_ted_due = 0;
    m_pd_due  = 0;
    if (st || nxt != m_state) begin
      m_sym = 0;
      win_ted.delete();
      win_pd.delete();
      if (nxt != m_state) q_evt.push_back('{cyc, nxt, m_relock});
      m_state = nxt;
    end else begin
      if (tv && ((m_state == S_TIM && m_sym >= SETTLE) || m_state == S_TRACK)) begin
        win_ted.push_back(abs_sat(te, WERR));
        if (win_ted.size() == LOCK_WIN) begin
          m_ted_mean = sum_q(win_ted);
          m_ted_due = 1;
          q_tmean.push_back(m_ted_mean);
          win_ted.delete();
        end
      end
      if (pv && ((m_state == S_FINE && m_sym >= SETTLE) || m_state == S_TRACK)) begin
        win_pd.push_back(abs_sat(pe, EW));
        if (win_pd.size() == LOCK_WIN) begin
          m_pd_mean = sum_q(win_pd);
          m_pd_due = 1;
          q_pmean.push_back(m_pd_mean);
          win_pd.delete();
        end
      end
      if (sv && m_sym < TIMEOUT) m_sym++;
    end
  endtask

  task automatic tick(input bit st, input bit cd);
    bit sv, tv, pv;
    int te, pe;
    sv = ($urandom_range(0, 99) < g_sym_pct);
    tv = sv ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
    pv = g_same_val ? tv : (sv ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0));
    te = rand_err(g_ted_mag);
    pe = g_pd_sat ? -(1 << 23) : rand_err(g_pd_mag);
    start_i = st; sym_val_i = sv; cfo_done_i = cd;
    ted_err_val_i = tv; ted_err_i = te[WERR-1:0];
    pd_err_val_i = pv;  pd_err_i  = pe[EW-1:0];
    @(posedge clk);
    cyc++;
    model_step(st, sv, tv, te, pv, pe, cd);
    #1;
    start_i = 1'b0;
    cfo_done_i = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state_o) != target && n < budget) begin
      tick(0, 0);
      n++;
    end
    chk(name, state_o, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_outs"}, {ted_en_o, coarse_en_o, cfo_en_o, lock_o, fail_o}, 0);
    chk({tag, "_relock"}, relock_cnt_o, 0);
  endtask

  // Scoreboard monitor: pops on every visible state change and every window result.
  initial begin
    int last_st;
    evt_t e;
    last_st = 0;
    forever begin
      @(negedge clk);
      if (int'(state_o) != last_st) begin
        if (q_evt.size() == 0) begin
          chk("evt_unexpected", state_o, last_st);
        end else begin
          e = q_evt.pop_front();
          chk("evt_state", state_o, e.st);
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_relock", relock_cnt_o, e.relock);
          chk("evt_outs", {ted_en_o, coarse_en_o, cfo_en_o, lock_o, fail_o}, exp_outs(e.st));
        end
        last_st = int'(state_o);
      end
      if (u_dut.u_ted_det.mean_val) begin
        if (q_tmean.size() == 0) chk("ted_mean_unexpected", u_dut.u_ted_det.mean_val, 0);
        else chk("ted_mean", u_dut.u_ted_det.mean, q_tmean.pop_front());
      end
      if (u_dut.u_pd_det.mean_val) begin
        if (q_pmean.size() == 0) chk("pd_mean_unexpected", u_dut.u_pd_det.mean_val, 0);
        else chk("pd_mean", u_dut.u_pd_det.mean, q_pmean.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; start_i = 1'b0; sym_val_i = 1'b0; cfo_done_i = 1'b0;
    ted_err_i = '0; ted_err_val_i = 1'b0; pd_err_i = '0; pd_err_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #1 reset_n = 1'b1;

    // Idle with random input activity and no start
    for (int k = 0; k < 10; k++) begin
      repeat (100) tick(0, 0);
      chk("idle_state", state_o, S_IDLE);
      chk("idle_outs", {ted_en_o, coarse_en_o, cfo_en_o, lock_o, fail_o}, 0);
    end

    // Nominal acquisition, then pd-only unlock, then coincident ted+pd unlock
    g_ted_mag = 100; g_pd_mag = 200; g_same_val = 1;
    tick(1, 0);
    run_until(S_COARSE, 1000, "nom_coarse");
    repeat (5) tick(0, 0);
    tick(0, 1);
    chk("nom_fine", state_o, S_FINE);
    run_until(S_TRACK, 1500, "nom_track");
    chk("nom_lock", lock_o, 1);
    g_pd_mag = 20000;
    run_until(S_FINE, 600, "unlk_pd");
    chk("unlk_pd_relock", relock_cnt_o, 1);
    g_pd_mag = 200;
    run_until(S_TRACK, 1500, "relock_track");
    g_ted_mag = 9000; g_pd_mag = 20000;
    run_until(S_TIM, 600, "unlk_ted_prio");
    chk("unlk_ted_relock", relock_cnt_o, 2);
    g_same_val = 0; g_ted_mag = 100; g_pd_mag = 200;

    // Async reset while in COARSE
    run_until(S_COARSE, 1000, "rst_coarse");
    repeat (3) tick(0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    if (m_state != S_IDLE) q_evt.push_back('{cyc, S_IDLE, 0});
    m_state = S_IDLE; m_sym = 0; m_tries = 0; m_relock = 0;
    m_ted_due = 0; m_pd_due = 0;
    win_ted.delete(); win_pd.delete(); q_tmean.delete(); q_pmean.delete();
    sym_val_i = 1'b0; ted_err_val_i = 1'b0; pd_err_val_i = 1'b0;
    repeat (3) begin @(posedge clk); cyc++; end
    #2 reset_n = 1'b1;

    // Timing never locks: FAIL at the TIMEOUT-th symbol, start recovers
    g_ted_mag = 10000;
    tick(1, 0);
    run_until(S_FAIL, 8000, "tmo_fail");
    chk("tmo_fail_o", fail_o, 1);
    tick(1, 0);
    chk("tmo_restart_state", state_o, S_TIM);
    chk("tmo_restart_fail", fail_o, 0);

    // start_i in the same cycle as a timing lock decision
    g_ted_mag = 100;
    n = 0;
    while (!u_dut.u_ted_det.mean_val && n < 2000) begin tick(0, 0); n++; end
    chk("coin_meanval", u_dut.u_ted_det.mean_val, 1);
    tick(1, 0);
    chk("coin_state", state_o, S_TIM);
    run_until(S_COARSE, 1000, "coin_coarse");

    // Fine acquisition never locks: two retries then FAIL; last attempt uses -2^23
    repeat (4) tick(0, 0);
    g_pd_mag = 30000;
    tick(0, 1);
    run_until(S_COARSE, 8000, "retry1");
    tick(0, 1);
    run_until(S_COARSE, 8000, "retry2");
    g_pd_sat = 1;
    tick(0, 1);
    run_until(S_FAIL, 8000, "retry_fail");
    chk("retry_fail_o", fail_o, 1);

    @(negedge clk);
    #1;
    chk("evt_queue_empty", q_evt.size(), 0);
    chk("ted_mean_queue_empty", q_tmean.size(), 0);
    chk("pd_mean_queue_empty", q_pmean.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
